// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder running entirely in the system clock domain.
// sclk/cs/mosi are synchronized and sclk edges are detected against a delayed copy.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              load_pending_q, load_pending_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              miso_q, miso_d;
  logic              load, tx_wr;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign tx_wr     = tx_valid & ~tx_full_q;

  always_comb begin
    state_d        = state_q;
    tx_buf_d       = tx_buf_q;
    tx_full_d      = tx_full_q;
    tx_shift_d     = tx_shift_q;
    rx_shift_d     = rx_shift_q;
    bit_cnt_d      = bit_cnt_q;
    load_pending_d = load_pending_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    load           = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d      = '0;
        load_pending_d = 1'b0;
        if (cs_fall) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: begin
        // cs deassert has priority over any coincident sclk edge
        if (cs_rise) begin
          state_d        = IDLE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d      = '0;
            rx_data_d      = {rx_shift_q[DATA_W-2:0], mosi_s};
            rx_valid_d     = 1'b1;
            load_pending_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (load_pending_q) begin
            load           = 1'b1;
            load_pending_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
    endcase
    if (load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
    // A write in the same cycle as a load lands after the load sampled the old content
    if (tx_wr) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data;
    end else if (load) begin
      tx_full_d = 1'b0;
    end
    miso_d = (state_d == ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q    <= '0;
      cs_sync_q      <= '0;
      mosi_sync_q    <= '0;
      sclk_prev_q    <= 1'b0;
      cs_prev_q      <= 1'b0;
      state_q        <= IDLE;
      tx_buf_q       <= '0;
      tx_full_q      <= 1'b0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      bit_cnt_q      <= '0;
      load_pending_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q    <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q    <= sclk_s;
      cs_prev_q      <= cs_s;
      state_q        <= state_d;
      tx_buf_q       <= tx_buf_d;
      tx_full_q      <= tx_full_d;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      bit_cnt_q      <= bit_cnt_d;
      load_pending_q <= load_pending_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
      miso_q         <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed + randomized bench for spi_slave_sync with a frame-level model
// of the one-entry transmit buffer and the master's view of both data lines.
module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, underrun, busy;

  int vectors = 0, miscompares = 0;
  int rx_cnt = 0, und_cnt = 0;
  logic [7:0] last_rx = 8'h00;

  // frame-level model
  logic       buf_full = 1'b0;
  logic [7:0] buf_val = 8'h00, cur_tx = 8'h00;
  int         exp_rx = 0, exp_und = 0;

  spi_slave_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      last_rx = rx_data;
    end
    if (underrun) und_cnt = und_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // a load takes the buffered byte if present, otherwise sends zeros and flags underrun
  task automatic model_load();
    if (buf_full) begin
      cur_tx   = buf_val;
      buf_full = 1'b0;
    end else begin
      cur_tx  = 8'h00;
      exp_und = exp_und + 1;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      wait_clk(1);
      t++;
    end
    chk("tx_ready before write", {31'd0, tx_ready}, 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    buf_full = 1'b1;
    buf_val  = v;
    wait_clk(1);
    chk("tx_ready after write", {31'd0, tx_ready}, 32'd0);
  endtask

  // master side: mosi changes on falling edge, miso sampled just before rising edge
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(8);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    model_load();
    wait_clk(6);
    chk("underrun count at frame start", und_cnt, exp_und);
    chk("busy after cs fall", {31'd0, busy}, 32'd1);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    wait_clk(8);
    chk("busy after cs rise", {31'd0, busy}, 32'd0);
    chk("miso idle", {31'd0, miso}, 32'd0);
  endtask

  task automatic frame(input logic [7:0] mo);
    logic [7:0] mi;
    xfer(mo, 8, mi);
    chk("master received byte", {24'd0, mi}, {24'd0, cur_tx});
    exp_rx++;
    chk("rx_valid count", rx_cnt, exp_rx);
    chk("rx_data", {24'd0, last_rx}, {24'd0, mo});
    model_load();
    chk("underrun count after frame", und_cnt, exp_und);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " miso"}, {31'd0, miso}, 32'd0);
    chk({tag, " tx_ready"}, {31'd0, tx_ready}, 32'd1);
    chk({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, " underrun"}, {31'd0, underrun}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] mi;
    // 1: reset held with sclk toggling
    cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk;
      wait_clk(4);
    end
    chk_reset_vals("reset");
    sclk = 1'b0;
    cs = 1'b1;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(8);
    chk_reset_vals("post-reset");

    // 2: single frame
    tx_write(8'h3C);
    cs_low();
    frame(8'hA5);
    cs_high();
    chk("tx_ready after single frame", {31'd0, tx_ready}, 32'd1);

    // 3: back-to-back frames with cs held low
    tx_write(8'h81);
    cs_low();
    tx_write(8'h7E);
    frame(8'h12);
    frame(8'h34);
    cs_high();

    // 4: abort after 5 bits, then a full frame
    tx_write(8'h5A);
    cs_low();
    xfer(8'hF0, 5, mi);
    chk("partial miso bits", {24'd0, mi}, {24'd0, cur_tx >> 3});
    cs = 1'b1;
    wait_clk(8);
    chk("busy after abort", {31'd0, busy}, 32'd0);
    chk("rx_valid count after abort", rx_cnt, exp_rx);
    tx_write(8'h66);
    cs_low();
    frame(8'h55);
    cs_high();

    // 5: underrun at frame start
    cs_low();
    tx_write(8'hE7);
    frame(8'h3D);
    cs_high();

    // 6: reset mid-frame
    tx_write(8'hF0);
    cs_low();
    xfer(8'h0F, 3, mi);
    reset_n = 1'b0;
    buf_full = 1'b0;
    wait_clk(2);
    chk_reset_vals("mid-frame reset");
    cs = 1'b1;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(8);
    chk_reset_vals("after mid-frame reset");
    tx_write(8'hC3);
    cs_low();
    frame(8'h99);
    cs_high();

    // randomized sessions: optional prefill, aborts, 1-3 back-to-back frames
    for (int it = 0; it < 24; it++) begin
      int nb, nf;
      if (!buf_full && $urandom_range(0, 3) != 0) tx_write(8'($urandom));
      cs_low();
      if ($urandom_range(0, 4) == 0) begin
        nb = $urandom_range(1, 7);
        xfer(8'($urandom), nb, mi);
        chk("random partial miso", {24'd0, mi}, {24'd0, cur_tx >> (8 - nb)});
        cs = 1'b1;
        wait_clk(8);
        chk("random abort busy", {31'd0, busy}, 32'd0);
        chk("random abort rx count", rx_cnt, exp_rx);
      end else begin
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
          if (!buf_full && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
          frame(8'($urandom));
        end
        cs_high();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
